// File: rtl/enc_pack_scheduler.sv
// Wave scheduler for the encoder binder packs: issues pack waves, waits out binder latency, hands waves to the accumulator.
// Optional stall counter port stall_cycles is enabled by defining ENC_SCHED_PERF_EN.
module enc_pack_scheduler #(
    parameter int unsigned NUM_PACKS      = 62,
    parameter int unsigned PACKS_PER_WAVE = 8,
    parameter int unsigned BIND_LAT       = 1,
    localparam int unsigned NUM_WAVES     = (NUM_PACKS + PACKS_PER_WAVE - 1) / PACKS_PER_WAVE,
    localparam int unsigned WAVE_W        = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      abort,
    output logic [NUM_PACKS-1:0]      pack_start,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic [WAVE_W-1:0]         acc_wave,
    output logic [PACKS_PER_WAVE-1:0] acc_mask,
    output logic                      busy,
    output logic                      encode_done
`ifdef ENC_SCHED_PERF_EN
   ,output logic [15:0]               stall_cycles
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned LAT_W    = (BIND_LAT > 1) ? $clog2(BIND_LAT) : 1;
    localparam int unsigned LAST_CNT = NUM_PACKS - (NUM_WAVES - 1) * PACKS_PER_WAVE;
    localparam logic [WAVE_W-1:0] LAST_WAVE = WAVE_W'(NUM_WAVES - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'((BIND_LAT > 0) ? BIND_LAT - 1 : 0);

    logic [2:0]        state, state_nxt;
    logic [WAVE_W-1:0] wave, wave_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic              accept;

    assign accept = (state == S_IDLE) && sample_valid;

    always_comb begin
        state_nxt = state;
        wave_nxt  = wave;
        lat_nxt   = lat_cnt;
        case (state)
            S_IDLE: begin
                if (sample_valid) begin
                    wave_nxt  = '0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (BIND_LAT > 0) begin
                    state_nxt = S_WAIT;
                    lat_nxt   = LAT_INIT;
                end else begin
                    state_nxt = S_ACC;
                end
            end
            S_WAIT: begin
                if (lat_cnt == '0) state_nxt = S_ACC;
                else               lat_nxt   = lat_cnt - 1'b1;
            end
            S_ACC: begin
                // Next wave is only issued after the handshake so shifted_hv stays stable under acc_valid.
                if (acc_ready) begin
                    if (wave == LAST_WAVE) begin
                        state_nxt = S_DONE;
                    end else begin
                        wave_nxt  = wave + 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state   <= S_IDLE;
            wave    <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            wave    <= wave_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    assign sample_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign acc_valid    = (state == S_ACC);
    assign encode_done  = (state == S_DONE);
    assign acc_wave     = acc_valid ? wave : '0;

    always_comb begin
        pack_start = '0;
        for (int unsigned p = 0; p < NUM_PACKS; p++) begin
            pack_start[p] = (state == S_ISSUE) && ((p / PACKS_PER_WAVE) == 32'(wave));
        end
    end

    // The final wave may be partially populated; only its real packs are flagged.
    always_comb begin
        acc_mask = '0;
        for (int unsigned i = 0; i < PACKS_PER_WAVE; i++) begin
            acc_mask[i] = acc_valid && ((wave != LAST_WAVE) || (i < LAST_CNT));
        end
    end

`ifdef ENC_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (nrst) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if ((state == S_ACC) && !acc_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// Scoreboard bench for enc_pack_scheduler: expected pack waves are queued on accept and popped by a monitor.
module tb_enc_pack_scheduler;

    localparam int NP = 62;
    localparam int PPW = 8;
    localparam int BL = 1;
    localparam int NW = (NP + PPW - 1) / PPW;
    localparam int WW = 3;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic sample_valid = 1'b0;
    logic abort = 1'b0;
    logic acc_ready = 1'b1;
    logic sample_ready, acc_valid, busy, encode_done;
    logic [NP-1:0] pack_start;
    logic [WW-1:0] acc_wave;
    logic [PPW-1:0] acc_mask;
`ifdef ENC_SCHED_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] stall2;
`endif

    logic sv2 = 1'b0;
    logic abort2 = 1'b0;
    logic acc_ready2 = 1'b1;
    logic ready2, acc_valid2, busy2, done2;
    logic [15:0] pack_start2;
    logic [0:0] acc_wave2;
    logic [7:0] acc_mask2;

    enc_pack_scheduler #(.NUM_PACKS(NP), .PACKS_PER_WAVE(PPW), .BIND_LAT(BL)) dut (
        .clk(clk), .nrst(nrst), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .abort(abort), .pack_start(pack_start), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_wave(acc_wave), .acc_mask(acc_mask), .busy(busy), .encode_done(encode_done)
`ifdef ENC_SCHED_PERF_EN
       ,.stall_cycles(stall_cycles)
`endif
    );

    enc_pack_scheduler #(.NUM_PACKS(16), .PACKS_PER_WAVE(8), .BIND_LAT(0)) dut2 (
        .clk(clk), .nrst(nrst), .sample_valid(sv2), .sample_ready(ready2),
        .abort(abort2), .pack_start(pack_start2), .acc_valid(acc_valid2), .acc_ready(acc_ready2),
        .acc_wave(acc_wave2), .acc_mask(acc_mask2), .busy(busy2), .encode_done(done2)
`ifdef ENC_SCHED_PERF_EN
       ,.stall_cycles(stall2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [WW-1:0]  w;
        logic [PPW-1:0] m;
    } acc_t;

    logic [NP-1:0] exp_pack_q[$];
    acc_t          exp_acc_q[$];

    bit mon_on = 0;
    bit busy_m = 0;
    bit hold_mode = 0;
    bit have_done = 0;
    bit prev_stall = 0;
    logic [WW-1:0] prev_wave = '0;
    int acc_cyc = 0;
    int stall_m = 0;
    int done_seen = 0;
    int accepts = 0;
    int last_done = 0;

    // One accepted sample: every wave fires its slice of packs, then offers it with a lane mask.
    task automatic push_sample();
        for (int w = 0; w < NW; w++) begin
            int lo, hi;
            logic [NP-1:0] v;
            acc_t a;
            lo = w * PPW;
            hi = (lo + PPW < NP) ? lo + PPW - 1 : NP - 1;
            v = '0;
            for (int p = lo; p <= hi; p++) v[p] = 1'b1;
            exp_pack_q.push_back(v);
            a.w = WW'(w);
            a.m = PPW'((1 << (hi - lo + 1)) - 1);
            exp_acc_q.push_back(a);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("sample_ready", sample_ready, !busy_m);
            chk("busy", busy, busy_m);
            if (prev_stall) begin
                chk("acc_held", acc_valid, 1'b1);
                chk("acc_held_wave", acc_wave, prev_wave);
                chk("no_start_in_stall", pack_start, '0);
            end
            if (pack_start != '0) begin
                if (exp_pack_q.size() == 0) chk("pack_start_unexpected", pack_start, '0);
                else chk("pack_start", pack_start, exp_pack_q.pop_front());
            end
            if (acc_valid) begin
                if (exp_acc_q.size() == 0) begin
                    chk("acc_valid_unexpected", acc_valid, 1'b0);
                end else begin
                    chk("acc_wave", acc_wave, exp_acc_q[0].w);
                    chk("acc_mask", acc_mask, exp_acc_q[0].m);
                    if (acc_ready && !abort && !nrst) void'(exp_acc_q.pop_front());
                end
                if (!acc_ready) stall_m++;
            end
            if (encode_done) begin
                chk("encode_done", encode_done,
                    busy_m && exp_pack_q.size() == 0 && exp_acc_q.size() == 0);
                if (busy_m) begin
                    chk("done_latency", cyc - acc_cyc, 1 + NW * (BL + 2) + stall_m);
`ifdef ENC_SCHED_PERF_EN
                    chk("stall_cycles", stall_cycles, stall_m);
`endif
                end
                done_seen++;
            end
            if (nrst) begin
                busy_m = 0;
                exp_pack_q.delete();
                exp_acc_q.delete();
            end else if (busy_m && abort) begin
                busy_m = 0;
                exp_pack_q.delete();
                exp_acc_q.delete();
            end else if (busy_m && encode_done) begin
                busy_m = 0;
                last_done = cyc;
                have_done = 1;
            end else if (!busy_m && sample_valid) begin
                if (hold_mode && have_done) chk("reaccept_cycle", cyc, last_done + 1);
                busy_m = 1;
                push_sample();
                acc_cyc = cyc;
                stall_m = 0;
                accepts++;
            end
            prev_stall = acc_valid && !acc_ready && !abort && !nrst;
            prev_wave = acc_wave;
        end
    end

    int mode = 0;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        case (mode)
            1: acc_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (acc_valid && acc_wave == 3'd3 && stall_left > 0) begin
                    acc_ready = 1'b0;
                    stall_left--;
                end else begin
                    acc_ready = 1'b1;
                end
            end
            default: acc_ready = 1'b1;
        endcase
    end

    task automatic pulse_sample();
        @(posedge clk); #1 sample_valid = 1'b1;
        @(posedge clk); #1 sample_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_seen;
        n = 0;
        while (done_seen == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", done_seen == start, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_m && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", busy_m, 1'b0);
    endtask

    logic [15:0] t5_pack [5] = '{16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 16'h0000};
    logic        t5_av   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        t5_w    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        t5_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int n;
        int d0;
        int a0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b0;
        mon_on = 1;
        @(negedge clk);
        chk("rst_ready", sample_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pack_start", pack_start, '0);
        chk("rst_acc_valid", acc_valid, 1'b0);
        chk("rst_acc_wave", acc_wave, '0);
        chk("rst_acc_mask", acc_mask, '0);
        chk("rst_done", encode_done, 1'b0);
`ifdef ENC_SCHED_PERF_EN
        chk("rst_stall", stall_cycles, 16'd0);
`endif

        // T5: zero binder latency, two full waves
        @(posedge clk); #1 sv2 = 1'b1;
        @(negedge clk);
        chk("t5_accept", ready2, 1'b1);
        @(posedge clk); #1 sv2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_pack_start", pack_start2, t5_pack[k]);
            chk("t5_acc_valid", acc_valid2, t5_av[k]);
            if (t5_av[k]) begin
                chk("t5_acc_wave", acc_wave2, t5_w[k]);
                chk("t5_acc_mask", acc_mask2, 8'hFF);
            end
            chk("t5_done", done2, t5_done[k]);
        end

        // T1: single sample, accumulator always ready
        mode = 0;
        pulse_sample();
        wait_done(200);
        wait_idle(10);

        // T2: five stall cycles on wave 3
        mode = 2;
        stall_left = 5;
        pulse_sample();
        wait_done(200);
`ifdef ENC_SCHED_PERF_EN
        @(negedge clk);
        chk("t2_stall_cycles", stall_cycles, 16'd5);
`endif
        wait_idle(10);
        mode = 0;

        // T3: abort while waiting on wave 2
        pulse_sample();
        n = 0;
        while (!pack_start[16] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_found_wave2", pack_start[16], 1'b1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t3_ready_after_abort", sample_ready, 1'b1);
        chk("t3_no_done", encode_done, 1'b0);
        pulse_sample();
        wait_done(200);
        wait_idle(10);

        // T4: sample_valid held across two encodes
        mode = 1;
        hold_mode = 1;
        have_done = 0;
        d0 = done_seen;
        a0 = accepts;
        @(posedge clk); #1 sample_valid = 1'b1;
        n = 0;
        while (done_seen < d0 + 2 && n < 800) begin
            @(posedge clk);
            n++;
        end
        #1 sample_valid = 1'b0;
        hold_mode = 0;
        chk("t4_done_count", done_seen - d0, 2);
        chk("t4_accepts", accepts - a0, 2);
        wait_idle(400);

        // Random samples with random back-pressure and occasional aborts
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            pulse_sample();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1 abort = 1'b1;
                @(posedge clk); #1 abort = 1'b0;
            end
            wait_idle(400);
        end
        mode = 0;

        // T6: reset pulse while a wave is offered
        pulse_sample();
        n = 0;
        while (!acc_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_reached_acc", acc_valid, 1'b1);
        @(posedge clk); #1 nrst = 1'b1;
        @(posedge clk); #1 nrst = 1'b0;
        @(negedge clk);
        chk("t6_ready", sample_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_acc_valid", acc_valid, 1'b0);
        chk("t6_pack_start", pack_start, '0);
        chk("t6_done", encode_done, 1'b0);
        chk("t6_acc_mask", acc_mask, '0);
`ifdef ENC_SCHED_PERF_EN
        chk("t6_stall", stall_cycles, 16'd0);
`endif
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
